// File: rtl/vga_plot_arbiter.sv
// vga_plot_arbiter
//   Arbitrates three pixel producers (screen clear, background redraw,
//   character sprite) onto a single VGA plot port. The arbiter uses fixed
//   priority (bit0 highest). A burst counter preempts the granted requester
//   after MAX_BURST pixels when another requester is waiting. The requester
//   preempted most recently is deprioritised until it is the only one left.
//
// Ports
//   clock     : sole clock, rising edge
//   reset     : asynchronous, active-high reset
//   req       : per-requester request
//   px_valid  : per-requester pixel strobe (honoured only for the granted one)
//   x_in      : 3 x 9-bit x coordinates, requester i at [9i+8:9i]
//   y_in      : 3 x 8-bit y coordinates, requester i at [8i+7:8i]
//   color_in  : 3 x 3-bit colors, requester i at [3i+2:3i]
//   gnt       : one-hot or zero grant
//   xCoord    : registered VGA x coordinate
//   yCoord    : registered VGA y coordinate
//   color     : registered VGA color
//   plot      : VGA write enable, one cycle per in-range accepted pixel
//   busy      : high whenever the arbiter is not idle
//   drop      : one-cycle pulse for an accepted out-of-range pixel
module vga_plot_arbiter #(
  parameter int MAX_BURST = 16,
  parameter int X_MAX     = 319,
  parameter int Y_MAX     = 239
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  px_valid,
  input  logic [26:0] x_in,
  input  logic [23:0] y_in,
  input  logic [8:0]  color_in,
  output logic [2:0]  gnt,
  output logic [8:0]  xCoord,
  output logic [7:0]  yCoord,
  output logic [2:0]  color,
  output logic        plot,
  output logic        busy,
  output logic        drop
);

  localparam int            CW   = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);
  localparam logic [8:0]    XLIM = 9'(X_MAX);
  localparam logic [7:0]    YLIM = 8'(Y_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state_q;
  logic [2:0]    gnt_q;
  logic [2:0]    lp_q;      // one-hot last_preempted, zero when cleared
  logic [CW-1:0] cnt_q;
  logic [8:0]    x_q;
  logic [7:0]    y_q;
  logic [2:0]    c_q;
  logic          plot_q;
  logic          drop_q;
  logic          busy_q;

  logic [2:0]    others_d;
  logic [2:0]    cand_d;
  logic [2:0]    winner_d;
  logic          accept_d;
  logic [8:0]    px_x_d;
  logic [7:0]    px_y_d;
  logic [2:0]    px_c_d;
  logic          in_range_d;
  logic [CW-1:0] cnt_d;
  logic          hold_d;
  logic          other_req_d;

  always_comb begin
    // Mask the last preempted requester only while someone else is asking.
    // When it is the sole requester, the plain request vector is used instead.
    others_d = req & ~lp_q;
    cand_d   = (|others_d) ? others_d : req;

    winner_d = '0;
    if (cand_d[0])      winner_d = 3'b001;
    else if (cand_d[1]) winner_d = 3'b010;
    else if (cand_d[2]) winner_d = 3'b100;

    // gnt_q is zero outside GRANT, so acceptance needs no state qualifier.
    accept_d = |(px_valid & gnt_q);

    px_x_d = '0;
    px_y_d = '0;
    px_c_d = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (gnt_q[i]) begin
        px_x_d = x_in[9*i +: 9];
        px_y_d = y_in[8*i +: 8];
        px_c_d = color_in[3*i +: 3];
      end
    end
    in_range_d = (px_x_d <= XLIM) && (px_y_d <= YLIM);

    cnt_d       = cnt_q + CW'(accept_d);
    hold_d      = |(req & gnt_q);
    other_req_d = |(req & ~gnt_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      lp_q    <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      c_q     <= '0;
      plot_q  <= 1'b0;
      drop_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // The pixel output path runs independently of the state transition.
      // A pixel accepted on the cycle the request drops is still emitted.
      if (accept_d) begin
        x_q    <= px_x_d;
        y_q    <= px_y_d;
        c_q    <= px_c_d;
        plot_q <= in_range_d;
        drop_q <= ~in_range_d;
      end else begin
        plot_q <= 1'b0;
        drop_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (|req) begin
            gnt_q   <= winner_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= GRANT;
          end
        end

        GRANT: begin
          if (!hold_d) begin
            gnt_q   <= '0;
            lp_q    <= '0;
            state_q <= RELEASE;
          end else if (cnt_d == MAXB) begin
            if (other_req_d) begin
              lp_q    <= gnt_q;
              gnt_q   <= '0;
              state_q <= RELEASE;
            end else begin
              cnt_q <= '0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        RELEASE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          gnt_q   <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign xCoord = x_q;
  assign yCoord = y_q;
  assign color  = c_q;
  assign plot   = plot_q;
  assign drop   = drop_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed testbench for vga_plot_arbiter with hand-computed expectations.
module tb_vga_plot_arbiter;

  logic        clock;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  px_valid;
  logic [26:0] x_in;
  logic [23:0] y_in;
  logic [8:0]  color_in;
  logic [2:0]  gnt;
  logic [8:0]  xCoord;
  logic [7:0]  yCoord;
  logic [2:0]  color;
  logic        plot;
  logic        busy;
  logic        drop;

  int errors = 0;
  int checks = 0;
  int plots  = 0;

  vga_plot_arbiter #(.MAX_BURST(16), .X_MAX(319), .Y_MAX(239)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .px_valid (px_valid),
    .x_in     (x_in),
    .y_in     (y_in),
    .color_in (color_in),
    .gnt      (gnt),
    .xCoord   (xCoord),
    .yCoord   (yCoord),
    .color    (color),
    .plot     (plot),
    .busy     (busy),
    .drop     (drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic set_px(input int i, input int x, input int y, input int c);
    x_in[9*i +: 9]     = 9'(x);
    y_in[8*i +: 8]     = 8'(y);
    color_in[3*i +: 3] = 3'(c);
  endtask

  initial begin
    reset = 1'b1; req = '0; px_valid = '0; x_in = '0; y_in = '0; color_in = '0;
    #1;
    check("rst_gnt", 32'(gnt), 0);
    check("rst_plot", 32'(plot), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_drop", 32'(drop), 0);
    check("rst_x", 32'(xCoord), 0);
    step();
    reset = 1'b0;

    // Priority with mask-free start: 110 -> requester 1
    req = 3'b110;
    step();
    check("t31_gnt", 32'(gnt), 32'b010);
    check("t31_busy", 32'(busy), 1);
    px_valid = 3'b010; set_px(1, 5, 7, 3);
    step();
    check("t31_plot", 32'(plot), 1);
    check("t31_x", 32'(xCoord), 5);
    check("t31_y", 32'(yCoord), 7);
    check("t31_c", 32'(color), 3);
    px_valid = '0;
    step();
    check("t31_plot0", 32'(plot), 0);
    check("t31_xhold", 32'(xCoord), 5);
    // Pixel at the corner accepted on the same cycle req drops
    req = 3'b000; px_valid = 3'b010; set_px(1, 319, 239, 6);
    step();
    check("t26_plot", 32'(plot), 1);
    check("t26_x", 32'(xCoord), 319);
    check("t26_y", 32'(yCoord), 239);
    check("t26_gnt", 32'(gnt), 0);
    check("t26_busy", 32'(busy), 1);
    px_valid = '0;
    step();
    check("t27_idle_busy", 32'(busy), 0);
    check("t27_idle_gnt", 32'(gnt), 0);

    // Requester 2 bursts; first pixel out of range; preempted by req0 after 16
    req = 3'b100;
    step();
    check("t32_gnt", 32'(gnt), 32'b100);
    req = 3'b101; px_valid = 3'b100; set_px(2, 320, 10, 1);
    step();
    check("t32_plot", 32'(plot), 0);
    check("t32_drop", 32'(drop), 1);
    check("t32_gnt_hold", 32'(gnt), 32'b100);
    for (int k = 1; k <= 15; k++) begin
      set_px(2, k, 1, 2);
      step();
      check("t33_plot", 32'(plot), 1);
      check("t33_x", 32'(xCoord), 32'(k));
      if (k == 1) check("t32_drop_once", 32'(drop), 0);
      if (k < 15) check("t33_gnt_burst", 32'(gnt), 32'b100);
      else        check("t33_gnt_release", 32'(gnt), 0);
    end
    px_valid = '0;
    step();
    check("t33_idle_gnt", 32'(gnt), 0);
    check("t33_idle_busy", 32'(busy), 0);
    step();
    check("t33_gnt0", 32'(gnt), 32'b001);
    req = 3'b100;
    step();
    check("t33_rel2_gnt", 32'(gnt), 0);
    step();
    check("t33_idle2_gnt", 32'(gnt), 0);
    step();
    check("t33_gnt2", 32'(gnt), 32'b100);
    req = '0;
    step();
    step();

    // Requester 1 alone streams 40 pixels; counter wraps without release
    req = 3'b010;
    step();
    check("t34_gnt_start", 32'(gnt), 32'b010);
    plots = 0;
    px_valid = 3'b010;
    for (int k = 0; k < 40; k++) begin
      set_px(1, k, 2, 5);
      step();
      if (gnt !== 3'b010) check("t34_gnt", 32'(gnt), 32'b010);
      if (plot) plots++;
    end
    check("t34_gnt_end", 32'(gnt), 32'b010);
    check("t34_plots", 32'(plots), 40);
    check("t34_lastx", 32'(xCoord), 39);
    px_valid = '0; req = '0;
    step();
    step();

    // Non-granted px_valid is ignored
    req = 3'b100;
    step();
    check("t35_gnt", 32'(gnt), 32'b100);
    px_valid = 3'b101; set_px(0, 11, 3, 1); set_px(2, 22, 3, 4);
    step();
    check("t35_plot", 32'(plot), 1);
    check("t35_x", 32'(xCoord), 22);
    check("t35_c", 32'(color), 4);
    px_valid = 3'b001;
    step();
    check("t35_plot_ign", 32'(plot), 0);
    check("t35_xhold", 32'(xCoord), 22);
    px_valid = 3'b100; set_px(2, 0, 240, 2);
    step();
    check("t22_ydrop", 32'(drop), 1);
    check("t22_yplot", 32'(plot), 0);

    // Asynchronous reset mid-burst
    set_px(2, 7, 5, 3);
    step();
    check("t36_plot_pre", 32'(plot), 1);
    #2 reset = 1'b1;
    #1;
    check("t36_plot", 32'(plot), 0);
    check("t36_gnt", 32'(gnt), 0);
    check("t36_busy", 32'(busy), 0);
    check("t36_x", 32'(xCoord), 0);
    step();
    check("t36_plot_held", 32'(plot), 0);
    reset = 1'b0; req = 3'b001; px_valid = '0;
    step();
    check("t36_gnt_after", 32'(gnt), 32'b001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
